// File: rtl/sdram_wb_posted_bridge.sv
// sdram_wb_posted_bridge: pipelined Wishbone slave to SDRAM controller host port with posted-write FIFO,
// read-after-write ordering and read timeout.
module sdram_wb_posted_bridge #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int WFIFO_DEPTH = 8,
  parameter int RD_TIMEOUT  = 1023
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             cyc_i,
  input  logic                             stb_i,
  input  logic                             we_i,
  input  logic [ADDR_W-1:0]                adr_i,
  input  logic [DATA_W-1:0]                dat_i,
  output logic [DATA_W-1:0]                dat_o,
  output logic                             ack_o,
  output logic                             err_o,
  output logic                             stall_o,
  output logic [$clog2(WFIFO_DEPTH):0]     wfifo_level,
  output logic [31:0]                      ctl_wr_addr,
  output logic [DATA_W-1:0]                ctl_wr_data,
  output logic                             ctl_wr_enable,
  output logic [31:0]                      ctl_rd_addr,
  output logic                             ctl_rd_enable,
  input  logic [DATA_W-1:0]                ctl_rd_data,
  input  logic                             ctl_rd_ready,
  input  logic                             ctl_busy
);
  localparam int AW = $clog2(WFIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam int EW = ADDR_W + DATA_W;
  typedef enum logic [2:0] {ST_IDLE, ST_WR_ISSUE, ST_WR_GAP, ST_WR_WAIT, ST_RD_ISSUE, ST_RD_WAIT} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] mem_q [WFIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rd_live_q, rd_live_d, ack_q, ack_d, err_q, err_d;
  logic [DATA_W-1:0] dat_q, dat_d, wdata_q, wdata_d;
  logic [31:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic empty, full, req, push, pop, rd_acc, rd_done, rd_to, rd_term;
  assign empty = level_q == '0;
  assign full = level_q == LW'(WFIFO_DEPTH);
  // Writes also stall behind a live read so terminations stay in acceptance order.
  assign stall_o = !rst_i && (we_i ? (full || rd_live_q) : !(empty && state_q == ST_IDLE));
  assign req = cyc_i && stb_i && !stall_o;
  assign push = req && we_i;
  assign rd_acc = req && !we_i;
  assign pop = state_q == ST_IDLE && !empty && !ctl_busy;
  assign rd_done = state_q == ST_RD_WAIT && ctl_rd_ready;
  assign rd_to = state_q == ST_RD_WAIT && !ctl_rd_ready && cnt_q == CW'(RD_TIMEOUT - 1);
  assign rd_term = rd_live_q && cyc_i;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = rd_acc ? ST_RD_ISSUE : pop ? ST_WR_ISSUE : ST_IDLE;
      ST_WR_ISSUE: state_d = ST_WR_GAP;
      ST_WR_GAP:   state_d = ST_WR_WAIT;
      ST_WR_WAIT:  state_d = ctl_busy ? ST_WR_WAIT : ST_IDLE;
      ST_RD_ISSUE: state_d = ctl_busy ? ST_RD_ISSUE : ST_RD_WAIT;
      ST_RD_WAIT:  state_d = (rd_done || rd_to) ? ST_IDLE : ST_RD_WAIT;
      default:     state_d = ST_IDLE;
    endcase
    wp_d = push ? wp_q + AW'(1) : wp_q;
    rp_d = pop ? rp_q + AW'(1) : rp_q;
    level_d = level_q + LW'(push) - LW'(pop);
    waddr_d = pop ? 32'(mem_q[rp_q][EW-1:DATA_W]) : waddr_q;
    wdata_d = pop ? mem_q[rp_q][DATA_W-1:0] : wdata_q;
    raddr_d = rd_acc ? 32'(adr_i) : raddr_q;
    cnt_d = state_q == ST_RD_WAIT ? cnt_q + CW'(1) : '0;
    rd_live_d = rd_acc ? 1'b1 : (rd_done || rd_to || !cyc_i) ? 1'b0 : rd_live_q;
    ack_d = push || (rd_done && rd_term);
    err_d = rd_to && rd_term;
    dat_d = (rd_done && rd_term) ? ctl_rd_data : dat_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
      cnt_q <= '0;
      rd_live_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      level_q <= level_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
      cnt_q <= cnt_d;
      rd_live_q <= rd_live_d;
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wp_q] <= {adr_i, dat_i};
  end
  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;
  assign wfifo_level = level_q;
  assign ctl_wr_addr = waddr_q;
  assign ctl_wr_data = wdata_q;
  assign ctl_wr_enable = state_q == ST_WR_ISSUE;
  assign ctl_rd_addr = raddr_q;
  assign ctl_rd_enable = state_q == ST_RD_ISSUE && !ctl_busy;
endmodule

// File: tb/tb_sdram_wb_posted_bridge.sv
// tb_sdram_wb_posted_bridge: directed scenarios against a small SDRAM controller model.
module tb_sdram_wb_posted_bridge;
  logic clk_i = 0, rst_i = 1, cyc_i = 0, stb_i = 0, we_i = 0;
  logic [23:0] adr_i = '0;
  logic [15:0] dat_i = '0, dat_o, ctl_wr_data, ctl_rd_data = '0;
  logic ack_o, err_o, stall_o, ctl_wr_enable, ctl_rd_enable, ctl_rd_ready = 0, ctl_busy = 0;
  logic [3:0] wfifo_level;
  logic [31:0] ctl_wr_addr, ctl_rd_addr;
  sdram_wb_posted_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
    .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o), .stall_o(stall_o),
    .wfifo_level(wfifo_level), .ctl_wr_addr(ctl_wr_addr), .ctl_wr_data(ctl_wr_data),
    .ctl_wr_enable(ctl_wr_enable), .ctl_rd_addr(ctl_rd_addr), .ctl_rd_enable(ctl_rd_enable),
    .ctl_rd_data(ctl_rd_data), .ctl_rd_ready(ctl_rd_ready), .ctl_busy(ctl_busy)
  );
  always #5 clk_i = ~clk_i;
  int total = 0, bad = 0;
  int cyc_n = 0, n_ack = 0, n_err = 0, n_rd = 0, n_both = 0, wr_cyc = 0, rd_cyc = 0, err_cyc = 0, rd_cnt = 0;
  logic rd_mute = 0;
  logic [15:0] last_dat = '0;
  logic [31:0] rd_addr_l = '0;
  logic [15:0] cmem [256];
  logic [31:0] wq_addr [$];
  logic [15:0] wq_data [$];
  int ack_cyc [$];
  always @(negedge clk_i) begin
    cyc_n++;
    ctl_rd_ready = 1'b0;
    if (ctl_wr_enable) begin
      wq_addr.push_back(ctl_wr_addr);
      wq_data.push_back(ctl_wr_data);
      cmem[ctl_wr_addr[7:0]] = ctl_wr_data;
      wr_cyc = cyc_n;
    end
    if (ctl_rd_enable) begin
      n_rd++;
      rd_cyc = cyc_n;
      rd_addr_l = ctl_rd_addr;
      rd_cnt = 3;
    end else if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0 && !rd_mute) begin
        ctl_rd_ready = 1'b1;
        ctl_rd_data = cmem[rd_addr_l[7:0]];
      end
    end
    if (ack_o) begin
      n_ack++;
      ack_cyc.push_back(cyc_n);
      last_dat = dat_o;
    end
    if (err_o) begin
      n_err++;
      err_cyc = cyc_n;
    end
    if (ack_o && err_o) n_both++;
  end
  task automatic clear_logs();
    wq_addr.delete();
    wq_data.delete();
    ack_cyc.delete();
    n_ack = 0;
    n_err = 0;
    n_rd = 0;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic wb_issue(input logic we, input logic [23:0] a, input logic [15:0] d, input int budget, output logic ok);
    int n = 0;
    cyc_i = 1;
    stb_i = 1;
    we_i = we;
    adr_i = a;
    dat_i = d;
    @(negedge clk_i);
    while (stall_o && n < budget) begin
      n++;
      @(negedge clk_i);
    end
    ok = !stall_o;
    @(posedge clk_i);
    #1;
    stb_i = 0;
  endtask
  task automatic test_reset();
    cyc_i = 1;
    stb_i = 1;
    we_i = 0;
    tick(3);
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    total++;
    if ({ack_o, err_o, ctl_wr_enable, ctl_rd_enable} !== 4'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 0000", {ack_o, err_o, ctl_wr_enable, ctl_rd_enable}); end
    total++;
    if ({dat_o, ctl_wr_data, ctl_wr_addr, ctl_rd_addr, wfifo_level} !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", {dat_o, ctl_wr_data, ctl_wr_addr, ctl_rd_addr, wfifo_level}); end
    stb_i = 0;
    cyc_i = 0;
    rst_i = 0;
    tick(2);
  endtask
  task automatic test_back_to_back();
    logic ok;
    logic [2:0] oks;
    clear_logs();
    wb_issue(1, 24'h10, 16'hAAAA, 0, ok); oks[0] = ok;
    wb_issue(1, 24'h11, 16'hBBBB, 0, ok); oks[1] = ok;
    wb_issue(1, 24'h12, 16'hCCCC, 0, ok); oks[2] = ok;
    cyc_i = 0;
    tick(30);
    total++;
    if (oks !== 3'b111) begin bad++; $display("FAIL b2b_accept: got %b want 111", oks); end
    total++;
    if (n_ack != 3 || ack_cyc.size() != 3 || ack_cyc[1] - ack_cyc[0] != 1 || ack_cyc[2] - ack_cyc[1] != 1) begin bad++; $display("FAIL b2b_acks: got %0d acks want 3 consecutive", n_ack); end
    total++;
    if (wq_addr.size() != 3) begin bad++; $display("FAIL b2b_pulses: got %0d want 3", wq_addr.size()); end
    else begin
      total++;
      if ({wq_addr[0], wq_data[0], wq_addr[1], wq_data[1], wq_addr[2], wq_data[2]} !== {32'h10, 16'hAAAA, 32'h11, 16'hBBBB, 32'h12, 16'hCCCC}) begin bad++; $display("FAIL b2b_order: got %h %h %h want 10/aaaa 11/bbbb 12/cccc", wq_data[0], wq_data[1], wq_data[2]); end
    end
    total++;
    if (wfifo_level !== 4'd0) begin bad++; $display("FAIL b2b_level: got %0d want 0", wfifo_level); end
  endtask
  task automatic test_fifo_full();
    logic ok;
    int n_ok = 0;
    clear_logs();
    ctl_busy = 1;
    for (int i = 0; i < 8; i++) begin
      wb_issue(1, 24'h100 + 24'(i), 16'h1000 + 16'(i), 0, ok);
      if (ok) n_ok++;
    end
    wb_issue(1, 24'h108, 16'h1008, 2, ok);
    total++;
    if (n_ok != 8 || n_ack != 8) begin bad++; $display("FAIL full_acks: got %0d/%0d want 8/8", n_ok, n_ack); end
    total++;
    if (ok !== 1'b0) begin bad++; $display("FAIL full_stall: accepted=%b want 0", ok); end
    total++;
    if (wfifo_level !== 4'd8) begin bad++; $display("FAIL full_level: got %0d want 8", wfifo_level); end
    ctl_busy = 0;
    wb_issue(1, 24'h108, 16'h1008, 20, ok);
    cyc_i = 0;
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL full_ninth: accepted=%b want 1", ok); end
    tick(60);
    total++;
    if (wq_addr.size() != 9) begin bad++; $display("FAIL full_drain: got %0d want 9", wq_addr.size()); end
    else begin
      total++;
      if ({wq_addr[0], wq_data[0], wq_addr[8], wq_data[8]} !== {32'h100, 16'h1000, 32'h108, 16'h1008}) begin bad++; $display("FAIL full_order: got %h/%h %h/%h want 100/1000 108/1008", wq_addr[0], wq_data[0], wq_addr[8], wq_data[8]); end
    end
    total++;
    if (wfifo_level !== 4'd0 || n_ack != 9) begin bad++; $display("FAIL full_end: level %0d acks %0d want 0 9", wfifo_level, n_ack); end
  endtask
  task automatic test_raw_order();
    logic ok1, ok2;
    clear_logs();
    wb_issue(1, 24'h20, 16'h1234, 0, ok1);
    wb_issue(0, 24'h20, 16'h0000, 30, ok2);
    tick(15);
    cyc_i = 0;
    total++;
    if ({ok1, ok2} !== 2'b11) begin bad++; $display("FAIL raw_accept: got %b want 11", {ok1, ok2}); end
    total++;
    if (n_rd != 1 || wq_addr.size() != 1 || rd_cyc <= wr_cyc) begin bad++; $display("FAIL raw_order: rd@%0d wr@%0d want rd after wr", rd_cyc, wr_cyc); end
    total++;
    if (n_ack != 2 || n_err != 0 || last_dat !== 16'h1234) begin bad++; $display("FAIL raw_data: acks %0d data %h want 2 1234", n_ack, last_dat); end
  endtask
  task automatic test_timeout();
    logic ok;
    clear_logs();
    rd_mute = 1;
    wb_issue(0, 24'h30, 16'h0, 5, ok);
    tick(1100);
    total++;
    if (n_err != 1 || n_ack != 0 || !ok) begin bad++; $display("FAIL to_term: err %0d ack %0d want 1 0", n_err, n_ack); end
    total++;
    if (err_cyc - rd_cyc != 1024) begin bad++; $display("FAIL to_delay: got %0d want 1024", err_cyc - rd_cyc); end
    total++;
    if (dat_o !== 16'h1234) begin bad++; $display("FAIL to_dat: got %h want 1234", dat_o); end
    rd_mute = 0;
    clear_logs();
    wb_issue(0, 24'h11, 16'h0, 5, ok);
    tick(12);
    cyc_i = 0;
    total++;
    if (n_ack != 1 || n_err != 0 || last_dat !== 16'hBBBB) begin bad++; $display("FAIL to_next: acks %0d data %h want 1 bbbb", n_ack, last_dat); end
  endtask
  task automatic test_async_reset();
    logic ok;
    clear_logs();
    ctl_busy = 1;
    for (int i = 0; i < 5; i++) wb_issue(1, 24'h50 + 24'(i), 16'h5000 + 16'(i), 0, ok);
    cyc_i = 0;
    ctl_busy = 0;
    tick(1);
    ctl_busy = 1;
    tick(4);
    total++;
    if (wq_addr.size() != 1 || wfifo_level !== 4'd4) begin bad++; $display("FAIL rst_setup: pulses %0d level %0d want 1 4", wq_addr.size(), wfifo_level); end
    #2;
    rst_i = 1;
    #1;
    total++;
    if ({wfifo_level, ctl_wr_addr, ctl_wr_data, ack_o, ctl_wr_enable, stall_o} !== '0) begin bad++; $display("FAIL rst_async: level %0d waddr %h wdata %h", wfifo_level, ctl_wr_addr, ctl_wr_data); end
    tick(2);
    rst_i = 0;
    ctl_busy = 0;
    tick(20);
    total++;
    if (wq_addr.size() != 1 || wfifo_level !== 4'd0) begin bad++; $display("FAIL rst_discard: pulses %0d level %0d want 1 0", wq_addr.size(), wfifo_level); end
  endtask
  task automatic test_cyc_drop();
    logic ok;
    int n = 0;
    clear_logs();
    wb_issue(0, 24'h10, 16'h0, 5, ok);
    while (n_rd == 0 && n < 20) begin n++; tick(1); end
    tick(1);
    cyc_i = 0;
    tick(10);
    total++;
    if (n_rd != 1 || n_ack != 0 || n_err != 0 || dat_o !== 16'h0) begin bad++; $display("FAIL drop_read: rd %0d ack %0d err %0d dat %h want 1 0 0 0", n_rd, n_ack, n_err, dat_o); end
    wb_issue(1, 24'h40, 16'h7777, 0, ok);
    tick(1);
    total++;
    if (!ok || n_ack != 1) begin bad++; $display("FAIL drop_write: accepted %b acks %0d want 1 1", ok, n_ack); end
    tick(12);
    wb_issue(0, 24'h40, 16'h0, 5, ok);
    tick(10);
    cyc_i = 0;
    total++;
    if (n_ack != 2 || last_dat !== 16'h7777) begin bad++; $display("FAIL drop_next: acks %0d data %h want 2 7777", n_ack, last_dat); end
    total++;
    if (n_both != 0) begin bad++; $display("FAIL ack_err_both: got %0d want 0", n_both); end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) cmem[i] = '0;
    test_reset();
    test_back_to_back();
    test_fifo_full();
    test_raw_order();
    test_timeout();
    test_async_reset();
    test_cyc_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_wb_posted_bridge.md
Name: sdram_wb_posted_bridge

Overview:
Parametrised Wishbone (pipelined, B4) slave bridge to the native SDRAM controller host port; successor to the single-transaction Wishbone SDRAM wrapper. It adds a write-posting FIFO so writes ack in one cycle, strict read-after-write ordering, a read timeout with error termination, and parametrised widths. It sits between the system Wishbone interconnect and sdram_controller; PHY wiring stays in the controller.

Parameters:
ADDR_W, 24, Wishbone word-address width; zero-extended to the 32-bit ctl_*_addr.
DATA_W, 16, data width on both sides.
WFIFO_DEPTH, 8, posted-write FIFO entries; power of 2, >=2.
RD_TIMEOUT, 1023, max cycles in ST_RD_WAIT before err; >=4.

Ports:
clk_i  in  1  system clock; also used by the controller.
rst_i  in  1  asynchronous, active-high reset.
cyc_i  in  1  Wishbone cycle valid.
stb_i  in  1  Wishbone strobe.
we_i  in  1  1=write, 0=read.
adr_i  in  ADDR_W  word address.
dat_i  in  DATA_W  write data.
dat_o  out  DATA_W  read data, valid with ack_o.
ack_o  out  1  one-cycle termination.
err_o  out  1  one-cycle error termination (read timeout).
stall_o  out  1  request not accepted this cycle.
wfifo_level  out  $clog2(WFIFO_DEPTH)+1  posted writes pending.
ctl_wr_addr  out  32  controller write address.
ctl_wr_data  out  DATA_W  controller write data.
ctl_wr_enable  out  1  one-cycle write command pulse.
ctl_rd_addr  out  32  controller read address.
ctl_rd_enable  out  1  one-cycle read command pulse.
ctl_rd_data  in  DATA_W  controller read data.
ctl_rd_ready  in  1  read data valid (single-cycle).
ctl_busy  in  1  controller busy.

Behaviour:
- Reset (async assert, sync release): FIFO emptied (posted writes discarded), FSM=ST_IDLE; dat_o=0, ack_o=0, err_o=0, ctl_wr_enable=0, ctl_rd_enable=0, ctl_*_addr=0, ctl_wr_data=0, wfifo_level=0. stall_o is combinational: 0 while in reset.
- Request = cyc_i & stb_i & !stall_o.
- Write accept: stall_o=1 if FIFO full. On accept, push {adr_i,dat_i}; ack_o=1 the next cycle. Push and pop in the same cycle both occur; level unchanged.
- Read accept: stall_o=1 unless FIFO empty and FSM=ST_IDLE (and not pending-read). On accept, latch address; FSM -> ST_RD_ISSUE.
- Drain FSM states: ST_IDLE, ST_WR_ISSUE, ST_WR_GAP, ST_WR_WAIT, ST_RD_ISSUE, ST_RD_WAIT.
- ST_IDLE: FIFO non-empty and !ctl_busy -> pop head into ctl_wr_addr/ctl_wr_data, -> ST_WR_ISSUE. Pending read with empty FIFO -> ST_RD_ISSUE.
- ST_WR_ISSUE: ctl_wr_enable=1 for exactly this cycle -> ST_WR_GAP (one cycle, ctl_busy ignored) -> ST_WR_WAIT; leave when ctl_busy=0 -> ST_IDLE.
- ST_RD_ISSUE: wait for !ctl_busy, then ctl_rd_enable=1 for one cycle, ctl_rd_addr=latched address; -> ST_RD_WAIT, timeout counter cleared.
- ST_RD_WAIT: ctl_rd_ready=1 -> dat_o<=ctl_rd_data, ack_o=1 next cycle, -> ST_IDLE. Counter reaches RD_TIMEOUT -> err_o=1 for one cycle, dat_o unchanged, -> ST_IDLE.
- cyc_i dropping while a read is outstanding: FSM finishes the controller read and discards the data; no ack_o/err_o.
- ack_o and err_o never both 1; at most one termination per accepted request, in acceptance order.
- Posted writes drain even when cyc_i=0.

Test Plan:
- Reset then 3 back-to-back writes (0x10/0xAAAA, 0x11/0xBBBB, 0x12/0xCCCC), ctl_busy=0 -> three acks on consecutive cycles; controller sees 3 write pulses, in order, with matching address/data; wfifo_level returns to 0.
- ctl_busy held high, 9 writes, WFIFO_DEPTH=8 -> 8 acks, stall_o=1 on the 9th, wfifo_level=8; release busy -> 9th accepted.
- Write 0x20/0x1234 then immediate read 0x20 -> read stalls until the write pulse completes; ctl_rd_enable comes after ctl_wr_enable; ack_o with dat_o=model data.
- Read with ctl_rd_ready never asserted -> err_o pulse exactly RD_TIMEOUT+1 cycles after ctl_rd_enable; no ack_o; next read works.
- rst_i asserted during ST_WR_WAIT with 4 writes queued -> outputs zero immediately (async); wfifo_level=0; no further write pulses after release.
- cyc_i dropped during ST_RD_WAIT -> no ack_o; following write accepted normally.
